// File: rtl/instr_decode_unit.sv
// rtl/instr_decode_unit.sv - instruction fetch register, family decoder and NZCV condition evaluation
module instr_decode_unit #(
   parameter logic [31:0] RESET_IR    = 32'hE1A0_0000,
   parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_ir,
   input  logic        flush,
   input  logic [31:0] mem_data,
   input  logic        mem_ready,
   input  logic        ld_cc,
   input  logic [3:0]  alu_flags,
   output logic        fetch_req,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [3:0]  family_number,
   output logic        COND,
   output logic        L,
   output logic        P,
   output logic        A,
   output logic [3:0]  flags
);

   typedef enum logic [1:0] {IDLE, FETCH, DECODED} state_t;

   state_t state, state_nxt;
   logic   capture;
   logic   cond_pass;

   // Priority-ordered family classification of bits 27:0 of an instruction word
   function automatic logic [3:0] decode_family(input logic [27:0] w);
      logic [3:0] fam;
      fam = 4'd0;
      if (w[27:4] == 24'h12FFF1)
         fam = 4'd8;
      else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[11:4] == 8'b0000_1001)
         fam = 4'd4;
      else if (w[27:22] == 6'b000000 && w[7:4] == 4'b1001)
         fam = 4'd2;
      else if (w[27:23] == 5'b00001 && w[7:4] == 4'b1001)
         fam = 4'd3;
      else if (w[27:25] == 3'b000 && w[7] && w[4] && w[6:5] != 2'b00)
         fam = 4'd5;
      else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[7:4] == 4'b0000)
         fam = 4'd6;
      else if ((w[27:23] == 5'b00010 && w[21:20] == 2'b10 && w[7:4] == 4'b0000) ||
               (w[27:23] == 5'b00110 && w[21:20] == 2'b10))
         fam = 4'd7;
      else begin
         case (w[27:25])
            3'b000: fam = 4'd0;
            3'b001: fam = 4'd1;
            3'b010: fam = 4'd9;
            3'b011: fam = w[4] ? 4'd11 : 4'd10;
            3'b100: fam = 4'd12;
            3'b101: fam = 4'd13;
            3'b110: fam = 4'd14;
            default: fam = w[24] ? 4'd15 : 4'd14;
         endcase
      end
      return fam;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush)
         state_nxt = IDLE;
      else begin
         case (state)
            IDLE:    if (ld_ir)     state_nxt = FETCH;
            FETCH:   if (mem_ready) state_nxt = DECODED;
            DECODED: if (ld_ir)     state_nxt = FETCH;
            default:                state_nxt = IDLE;
         endcase
      end
   end

   assign fetch_req = (state == FETCH);
   assign ir_valid  = (state == DECODED);
   assign capture   = (state == FETCH) && mem_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir            <= RESET_IR;
         family_number <= 4'd0;
         L             <= 1'b0;
         P             <= 1'b0;
         A             <= 1'b0;
      end else if (capture) begin
         ir            <= mem_data;
         family_number <= decode_family(mem_data[27:0]);
         L             <= mem_data[20];
         P             <= mem_data[24];
         A             <= mem_data[21];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flags <= RESET_FLAGS;
      else if (ld_cc)
         flags <= alu_flags;
   end

   // flags = {N,Z,C,V}
   always_comb begin
      cond_pass = 1'b0;
      case (ir[31:28])
         4'h0: cond_pass = flags[2];
         4'h1: cond_pass = !flags[2];
         4'h2: cond_pass = flags[1];
         4'h3: cond_pass = !flags[1];
         4'h4: cond_pass = flags[3];
         4'h5: cond_pass = !flags[3];
         4'h6: cond_pass = flags[0];
         4'h7: cond_pass = !flags[0];
         4'h8: cond_pass = flags[1] && !flags[2];
         4'h9: cond_pass = !flags[1] || flags[2];
         4'hA: cond_pass = (flags[3] == flags[0]);
         4'hB: cond_pass = (flags[3] != flags[0]);
         4'hC: cond_pass = !flags[2] && (flags[3] == flags[0]);
         4'hD: cond_pass = flags[2] || (flags[3] != flags[0]);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign COND = cond_pass && ir_valid;

endmodule

// File: tb/tb_instr_decode_unit.sv
// tb/tb_instr_decode_unit.sv - directed self-checking bench for instr_decode_unit
module tb_instr_decode_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_ir;
   logic        flush;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        ld_cc;
   logic [3:0]  alu_flags;
   logic        fetch_req;
   logic [31:0] ir;
   logic        ir_valid;
   logic [3:0]  family_number;
   logic        COND;
   logic        L;
   logic        P;
   logic        A;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_decode_unit dut (
      .clk(clk), .rst(rst), .ld_ir(ld_ir), .flush(flush),
      .mem_data(mem_data), .mem_ready(mem_ready), .ld_cc(ld_cc), .alu_flags(alu_flags),
      .fetch_req(fetch_req), .ir(ir), .ir_valid(ir_valid), .family_number(family_number),
      .COND(COND), .L(L), .P(P), .A(A), .flags(flags)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] data, input int waits);
      ld_ir = 1'b1;
      tick();
      ld_ir = 1'b0;
      repeat (waits) tick();
      mem_data  = data;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
   endtask

   // Expected COND per cond code (bit index = ir[31:28]) for each NZCV value
   logic [3:0]  sweep_flags [6] = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b1000, 4'b0110};
   logic [15:0] sweep_mask  [6] = '{16'h56AA, 16'h66A9, 16'h55A6, 16'h565A, 16'h6A9A, 16'h66A5};

   initial begin
      int fr_cycles;
      logic [15:0] mask;
      logic [3:0]  cc;

      rst = 1'b1; ld_ir = 1'b0; flush = 1'b0; mem_data = 32'h0;
      mem_ready = 1'b0; ld_cc = 1'b0; alu_flags = 4'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      check("rst_ir", ir, 32'hE1A00000);
      check("rst_ir_valid", ir_valid, 0);
      check("rst_cond", COND, 0);
      check("rst_flags", flags, 4'b0000);
      check("rst_fetch_req", fetch_req, 0);
      check("rst_family", family_number, 0);

      // zero-wait ADD fetch
      ld_ir = 1'b1;
      tick();
      ld_ir = 1'b0;
      check("add_fetch_req", fetch_req, 1);
      check("add_valid_early", ir_valid, 0);
      mem_data = 32'hE0821003; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("add_ir", ir, 32'hE0821003);
      check("add_valid", ir_valid, 1);
      check("add_family", family_number, 0);
      check("add_cond", COND, 1);
      check("add_lpa", {L, P, A}, 3'b000);
      check("add_fetch_req_off", fetch_req, 0);

      // LDR with three wait cycles; ld_ir during FETCH must be ignored
      fr_cycles = 0;
      ld_ir = 1'b1;
      tick();
      if (fetch_req) fr_cycles++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (fetch_req) fr_cycles++;
      end
      ld_ir = 1'b0;
      check("ldr_valid_waiting", ir_valid, 0);
      mem_data = 32'hE5912004; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("ldr_fetch_cycles", fr_cycles, 4);
      check("ldr_family", family_number, 9);
      check("ldr_l", L, 1);
      check("ldr_p", P, 1);
      check("ldr_valid", ir_valid, 1);

      fetch(32'h00210392, 0);
      check("mla_family", family_number, 2);
      check("mla_a", A, 1);
      check("mla_cond_eq", COND, 0);

      fetch(32'hE12FFF1E, 0);
      check("bx_family", family_number, 8);

      fetch(32'hE1091092, 0);
      check("swp_family", family_number, 4);
      fetch(32'hE1D320B4, 0);
      check("ldrh_family", family_number, 5);
      fetch(32'hE7910002, 0);
      check("ldr_reg_family", family_number, 10);
      fetch(32'hE7910012, 0);
      check("undef_family", family_number, 11);
      fetch(32'hE329F01F, 0);
      check("msr_imm_family", family_number, 7);

      // BEQ: flag update is visible only from the next cycle
      fetch(32'h0A000010, 0);
      check("beq_family", family_number, 13);
      check("beq_cond_z0", COND, 0);
      ld_cc = 1'b1; alu_flags = 4'b0100;
      #1;
      check("beq_cond_same_cycle", COND, 0);
      tick();
      ld_cc = 1'b0;
      check("beq_flags", flags, 4'b0100);
      check("beq_cond_next", COND, 1);

      // flush beats mem_ready and ld_ir; ld_cc still loads
      ld_ir = 1'b1;
      tick();
      ld_ir = 1'b0;
      check("flush_pre_fetch_req", fetch_req, 1);
      check("flush_pre_valid", ir_valid, 0);
      flush = 1'b1; mem_ready = 1'b1; ld_ir = 1'b1; mem_data = 32'hDEADBEEF;
      ld_cc = 1'b1; alu_flags = 4'b0110;
      tick();
      flush = 1'b0; mem_ready = 1'b0; ld_ir = 1'b0; ld_cc = 1'b0;
      check("flush_ir_kept", ir, 32'h0A000010);
      check("flush_valid", ir_valid, 0);
      check("flush_fetch_req", fetch_req, 0);
      check("flush_flags", flags, 4'b0110);
      check("flush_cond", COND, 0);
      mem_ready = 1'b1; mem_data = 32'h12345678;
      tick();
      mem_ready = 1'b0;
      check("idle_mem_ready_ignored", ir, 32'h0A000010);

      fetch(32'hFF000000, 0);
      check("swi_family", family_number, 15);
      check("swi_cond_nv", COND, 0);
      check("swi_p", P, 1);

      // asynchronous reset mid-fetch
      ld_ir = 1'b1;
      tick();
      ld_ir = 1'b0;
      check("arst_pre_fetch_req", fetch_req, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_fetch_req", fetch_req, 0);
      check("arst_ir", ir, 32'hE1A00000);
      check("arst_valid", ir_valid, 0);
      check("arst_family", family_number, 0);
      check("arst_lpa", {L, P, A}, 3'b000);
      check("arst_flags", flags, 4'b0000);
      check("arst_cond", COND, 0);
      tick();
      rst = 1'b0; mem_ready = 1'b1; mem_data = 32'hE5912004;
      tick();
      mem_ready = 1'b0;
      check("arst_late_ready_valid", ir_valid, 0);
      check("arst_late_ready_ir", ir, 32'hE1A00000);
      check("arst_late_fetch_req", fetch_req, 0);

      // condition code sweep
      for (int f = 0; f < 6; f++) begin
         ld_cc = 1'b1; alu_flags = sweep_flags[f];
         tick();
         ld_cc = 1'b0;
         mask = sweep_mask[f];
         for (int c = 0; c < 16; c++) begin
            cc = c[3:0];
            fetch({cc, 28'h0A00010}, 0);
            check($sformatf("cond_%0h_nzcv_%b", cc, sweep_flags[f]), COND, mask[c]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
